// File: rtl/vga_frame_capture.sv
// vga_frame_capture: VGA sink monitor that tracks sync timing and streams each captured pixel as an addressed write word.
module vga_frame_capture #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CHAN_W     = 10,
    parameter int OUT_BPC    = 1,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   blank,
    input  logic [CHAN_W-1:0]      red,
    input  logic [CHAN_W-1:0]      green,
    input  logic [CHAN_W-1:0]      blue,
    input  logic                   cap_en,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [3*OUT_BPC-1:0]   wr_data,
    output logic                   frame_done,
    output logic [15:0]            frame_count,
    output logic                   overflow,
    output logic                   timing_err,
    output logic                   busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL + 1) + 1;
    localparam int VW = $clog2(V_TOTAL + 1) + 1;
    localparam int DW = 3 * OUT_BPC;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_W + DW;
    localparam logic [HW-1:0] H_BACK_END = HW'(H_BACK - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_LEN = HW'(H_SYNC);
    localparam logic [HW-1:0] H_TOT_LEN  = HW'(H_TOTAL);
    localparam logic [VW-1:0] V_BACK_END = VW'(V_BACK - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SYNC_LEN = VW'(V_SYNC);
    localparam logic [VW-1:0] V_TOT_LEN  = VW'(V_TOTAL);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_BACK, S_ACT, S_FRONT} phase_t;

    phase_t h_state, h_nxt, v_state, v_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt, hw, hper;
    logic [VW-1:0] vcnt, vcnt_nxt, vw, vper;
    logic hs, vs, hs_d, vs_d, hs_rise, hs_fall, vs_rise, vs_fall;
    logic h_seen, v_seen, armed;
    logic [ADDR_W-1:0] addr_cnt;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wp, rp;
    logic [AW:0] count;
    logic [DW-1:0] pix_data;
    logic push, pop, push_ok, push_last, drop, fd_nxt;
    logic unused_ok;

    assign hs      = hsync == 1'(HS_POL);
    assign vs      = vsync == 1'(VS_POL);
    assign hs_rise = pix_en && hs && !hs_d;
    assign hs_fall = pix_en && !hs && hs_d;
    assign vs_rise = pix_en && vs && !vs_d;
    assign vs_fall = pix_en && !vs && vs_d;
    assign pix_data  = blank ? {red[CHAN_W-1 -: OUT_BPC], green[CHAN_W-1 -: OUT_BPC], blue[CHAN_W-1 -: OUT_BPC]} : '0;
    assign unused_ok = ^{red, green, blue};

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_d    <= 1'b0;
            vs_d    <= 1'b0;
            h_state <= S_IDLE;
            v_state <= S_IDLE;
            hcnt    <= '0;
            vcnt    <= '0;
        end else if (pix_en) begin
            hs_d    <= hs;
            vs_d    <= vs;
            h_state <= h_nxt;
            v_state <= v_nxt;
            hcnt    <= hcnt_nxt;
            vcnt    <= vcnt_nxt;
        end
    end

    // next-state values describe the pixel currently being sampled
    always_comb begin
        h_nxt    = h_state;
        hcnt_nxt = hcnt + 1'b1;
        if (hs_rise) begin
            h_nxt    = S_SYNC;
            hcnt_nxt = '0;
        end else if (h_state == S_SYNC && !hs) begin
            h_nxt    = S_BACK;
            hcnt_nxt = '0;
        end else if (h_state == S_BACK && hcnt == H_BACK_END) begin
            h_nxt    = S_ACT;
            hcnt_nxt = '0;
        end else if (h_state == S_ACT && hcnt == H_ACT_END) begin
            h_nxt    = S_FRONT;
            hcnt_nxt = '0;
        end
    end

    always_comb begin
        v_nxt    = v_state;
        vcnt_nxt = vcnt;
        if (vs_rise) begin
            v_nxt    = S_SYNC;
            vcnt_nxt = '0;
        end else if (v_state == S_SYNC && !vs) begin
            v_nxt    = S_BACK;
            vcnt_nxt = '0;
        end else if (hs_rise) begin
            vcnt_nxt = vcnt + 1'b1;
            if (v_state == S_BACK && vcnt == V_BACK_END) begin
                v_nxt    = S_ACT;
                vcnt_nxt = '0;
            end else if (v_state == S_ACT && vcnt == V_ACT_END) begin
                v_nxt    = S_FRONT;
                vcnt_nxt = '0;
            end
        end
    end

    always_comb begin
        push      = pix_en && armed && h_nxt == S_ACT && v_nxt == S_ACT;
        pop       = wr_valid && wr_ready;
        push_ok   = push && (count != FULL || pop);
        push_last = addr_cnt == LAST_ADDR;
        drop      = push && !push_ok;
        fd_nxt    = (pop && head[EW-1]) || (drop && push_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hw         <= '0;
            hper       <= '0;
            vw         <= '0;
            vper       <= '0;
            h_seen     <= 1'b0;
            v_seen     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            if (hs_rise) begin
                hw     <= HW'(1);
                hper   <= HW'(1);
                h_seen <= 1'b1;
            end else if (pix_en) begin
                if (hs && hw != '1) hw <= hw + 1'b1;
                if (hper != '1) hper <= hper + 1'b1;
            end
            if (vs_rise) begin
                vw     <= VW'(1);
                vper   <= VW'(1);
                v_seen <= 1'b1;
            end else if (hs_rise) begin
                if (vs && vw != '1) vw <= vw + 1'b1;
                if (vper != '1) vper <= vper + 1'b1;
            end
            if ((h_seen && ((hs_fall && hw != H_SYNC_LEN) || (hs_rise && hper != H_TOT_LEN))) ||
                (v_seen && ((vs_fall && vw != V_SYNC_LEN) || (vs_rise && vper != V_TOT_LEN))))
                timing_err <= 1'b1;
        end
    end

    // armed drops after the last pixel so busy reflects only the frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            armed    <= 1'b0;
            addr_cnt <= '0;
        end else if (vs_rise) begin
            armed    <= cap_en;
            addr_cnt <= '0;
        end else if (push) begin
            addr_cnt <= addr_cnt + 1'b1;
            if (push_last) armed <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= {push_last, addr_cnt, pix_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp          <= '0;
            rp          <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count       <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
            overflow    <= overflow || drop;
            frame_done  <= fd_nxt;
            frame_count <= frame_count + 16'(fd_nxt);
        end
    end

    assign head     = mem[rp];
    assign wr_valid = count != '0;
    assign wr_addr  = wr_valid ? head[DW +: ADDR_W] : '0;
    assign wr_data  = wr_valid ? head[DW-1:0] : '0;
    assign busy     = armed || wr_valid;
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed scenario tests for the VGA frame capture block on a tiny 8x4 raster.
module tb_vga_frame_capture;
    logic clk = 1'b0;
    logic reset, pix_en, hsync, vsync, blank, cap_en, wr_ready;
    logic [9:0] red, green, blue;
    logic wr_valid, frame_done, overflow, timing_err, busy;
    logic [4:0] wr_addr;
    logic [2:0] wr_data;
    logic [15:0] frame_count;

    int n_cmp = 0, n_bad = 0;
    int gl = 0, gp = 0, bad_line = -1, stall_line = -1, bx = -1, by = -1;
    logic cap = 1'b0;
    int n_got = 0, fd_cnt = 0;
    logic [4:0] ga [0:1023];
    logic [2:0] gd [0:1023];

    vga_frame_capture #(
        .H_ACTIVE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(0), .VS_POL(0), .CHAN_W(10), .OUT_BPC(1), .ADDR_W(5), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .blank(blank),
        .red(red), .green(green), .blue(blue), .cap_en(cap_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_count(frame_count), .overflow(overflow),
        .timing_err(timing_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_valid && wr_ready && n_got < 1024) begin
            ga[n_got] = wr_addr;
            gd[n_got] = wr_data;
            n_got++;
        end
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    function automatic logic [2:0] exp_d(int a);
        return 3'((a % 8) ^ (a / 8));
    endfunction

    // one pixel per two clocks; raster is 7 lines of 12 pixels (13 on the bad line)
    task automatic step();
        int hsw, len, x, y;
        logic [2:0] v;
        hsw = (gl == bad_line) ? 3 : 2;
        len = hsw + 10;
        x = gp - hsw - 1;
        y = gl - 2;
        v = 3'(x ^ y);
        @(posedge clk); #1;
        hsync    = (gp < hsw) ? 1'b0 : 1'b1;
        vsync    = (gl == 0) ? 1'b0 : 1'b1;
        blank    = (x >= 0 && x < 8 && y >= 0 && y < 4 && !(x == bx && y == by));
        red      = {v[2], 9'h155};
        green    = {v[1], 9'h0AA};
        blue     = {v[0], 9'h1FF};
        wr_ready = (gl != stall_line);
        cap_en   = cap;
        pix_en   = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        gp++;
        if (gp == len) begin
            gp = 0;
            gl = (gl + 1) % 7;
        end
    endtask

    task automatic run_to(int l, int p);
        while (!(gl == l && gp == p)) step();
    endtask

    task automatic run_frame();
        step();
        run_to(0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({wr_valid, frame_done, overflow, timing_err, busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000", {wr_valid, frame_done, overflow, timing_err, busy});
        end
        n_cmp++;
        if ({frame_count, wr_addr, wr_data} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_values: got count %0d addr %0d data %0d want 0", frame_count, wr_addr, wr_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_two_frames();
        int base, fd0;
        cap = 1'b1;
        base = n_got;
        fd0 = fd_cnt;
        run_frame();
        run_frame();
        n_cmp++;
        if (n_got - base !== 64) begin
            n_bad++;
            $display("FAIL two_frames_writes: got %0d want 64", n_got - base);
        end
        for (int i = 0; i < 64; i++) begin
            n_cmp++;
            if (ga[base+i] !== 5'(i % 32) || gd[base+i] !== exp_d(i % 32)) begin
                n_bad++;
                $display("FAIL two_frames_word %0d: got addr %0d data %0d want addr %0d data %0d",
                         i, ga[base+i], gd[base+i], i % 32, exp_d(i % 32));
            end
        end
        n_cmp++;
        if (fd_cnt - fd0 !== 2 || frame_count !== 16'd2) begin
            n_bad++;
            $display("FAIL two_frames_done: got pulses %0d count %0d want 2 and 2", fd_cnt - fd0, frame_count);
        end
        n_cmp++;
        if (timing_err !== 1'b0 || overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL two_frames_flags: got timing_err %b overflow %b want 0 0", timing_err, overflow);
        end
    endtask

    task automatic test_blank();
        int base;
        bx = 5;
        by = 1;
        base = n_got;
        run_frame();
        bx = -1;
        by = -1;
        n_cmp++;
        if (n_got - base !== 32) begin
            n_bad++;
            $display("FAIL blank_writes: got %0d want 32", n_got - base);
        end
        n_cmp++;
        if (ga[base+13] !== 5'd13 || gd[base+13] !== 3'b000) begin
            n_bad++;
            $display("FAIL blank_pixel: got addr %0d data %0d want addr 13 data 0", ga[base+13], gd[base+13]);
        end
        n_cmp++;
        if (gd[base+12] !== 3'd5) begin
            n_bad++;
            $display("FAIL blank_neighbour: got data %0d want 5", gd[base+12]);
        end
    endtask

    task automatic test_overflow();
        int base, fd0, ea;
        stall_line = 3;
        base = n_got;
        fd0 = fd_cnt;
        run_to(4, 0);
        n_cmp++;
        if (wr_valid !== 1'b1 || wr_addr !== 5'd8 || wr_data !== 3'd1) begin
            n_bad++;
            $display("FAIL overflow_hold: got valid %b addr %0d data %0d want 1 8 1", wr_valid, wr_addr, wr_data);
        end
        n_cmp++;
        if (n_got - base !== 8 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_stall: got writes %0d overflow %b want 8 1", n_got - base, overflow);
        end
        stall_line = -1;
        run_to(0, 0);
        n_cmp++;
        if (n_got - base !== 28 || fd_cnt - fd0 !== 1) begin
            n_bad++;
            $display("FAIL overflow_total: got writes %0d pulses %0d want 28 1", n_got - base, fd_cnt - fd0);
        end
        for (int i = 0; i < 28; i++) begin
            ea = (i < 12) ? i : i + 4;
            n_cmp++;
            if (ga[base+i] !== 5'(ea) || gd[base+i] !== exp_d(ea)) begin
                n_bad++;
                $display("FAIL overflow_word %0d: got addr %0d data %0d want addr %0d data %0d",
                         i, ga[base+i], gd[base+i], ea, exp_d(ea));
            end
        end
    endtask

    task automatic test_cap_midframe();
        int base, fd0;
        cap = 1'b0;
        base = n_got;
        run_to(3, 0);
        cap = 1'b1;
        run_to(0, 0);
        n_cmp++;
        if (n_got - base !== 0) begin
            n_bad++;
            $display("FAIL cap_mid_nowrite: got %0d writes want 0", n_got - base);
        end
        fd0 = fd_cnt;
        run_to(2, 3);
        step();
        n_cmp++;
        if (wr_valid !== 1'b1 || wr_addr !== 5'd0) begin
            n_bad++;
            $display("FAIL cap_latency: got valid %b addr %0d want 1 0", wr_valid, wr_addr);
        end
        run_to(0, 0);
        n_cmp++;
        if (n_got - base !== 32 || fd_cnt - fd0 !== 1) begin
            n_bad++;
            $display("FAIL cap_frame: got writes %0d pulses %0d want 32 1", n_got - base, fd_cnt - fd0);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (ga[base+i] !== 5'(i)) begin
                n_bad++;
                $display("FAIL cap_addr %0d: got %0d want %0d", i, ga[base+i], i);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int base;
        run_to(4, 6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({wr_valid, frame_done, overflow, timing_err, busy} !== 5'b0 || frame_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got flags %b count %0d want 00000 0",
                     {wr_valid, frame_done, overflow, timing_err, busy}, frame_count);
        end
        base = n_got;
        run_to(0, 0);
        n_cmp++;
        if (n_got - base !== 0) begin
            n_bad++;
            $display("FAIL reset_mid_partial: got %0d writes want 0", n_got - base);
        end
        run_frame();
        n_cmp++;
        if (n_got - base !== 32 || frame_count !== 16'd1 || timing_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_next: got writes %0d count %0d timing_err %b want 32 1 0",
                     n_got - base, frame_count, timing_err);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (ga[base+i] !== 5'(i) || gd[base+i] !== exp_d(i)) begin
                n_bad++;
                $display("FAIL reset_mid_word %0d: got addr %0d data %0d want addr %0d data %0d",
                         i, ga[base+i], gd[base+i], i, exp_d(i));
            end
        end
    endtask

    task automatic test_hsync_width();
        int base;
        bad_line = 3;
        base = n_got;
        run_to(3, 4);
        n_cmp++;
        if (timing_err !== 1'b1) begin
            n_bad++;
            $display("FAIL hsync_width_err: got %b want 1", timing_err);
        end
        run_to(0, 0);
        bad_line = -1;
        n_cmp++;
        if (n_got - base !== 32) begin
            n_bad++;
            $display("FAIL hsync_width_writes: got %0d want 32", n_got - base);
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (ga[base+i] !== 5'(i) || gd[base+i] !== exp_d(i)) begin
                n_bad++;
                $display("FAIL hsync_width_word %0d: got addr %0d data %0d want addr %0d data %0d",
                         i, ga[base+i], gd[base+i], i, exp_d(i));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        pix_en   = 1'b0;
        hsync    = 1'b1;
        vsync    = 1'b1;
        blank    = 1'b0;
        red      = '0;
        green    = '0;
        blue     = '0;
        cap_en   = 1'b0;
        wr_ready = 1'b1;
        test_reset();
        test_two_frames();
        test_blank();
        test_overflow();
        test_cap_midframe();
        test_reset_midframe();
        test_hsync_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
